// File: rtl/framer_pkg.sv
// Shared types and helpers for the sample_framer block.
package framer_pkg;

  typedef enum logic [1:0] {IDLE, START, STREAM, GAP} state_t;

  localparam int CNT_W = 16;

  // Bits needed to hold a count of 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sample_framer_sync_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count and full/empty flags.
// A write while full is taken only when a read frees a slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sample_framer.sv
// Buffers a signed sample stream and re-emits it as fixed-length frames with a start pulse.
// Define SAMPLE_FRAMER_DROP_EN to make the input non-stalling (overflow samples are counted and dropped).
//
//   state  | meaning
//   IDLE   | waiting for enable and buffered data
//   START  | one-cycle frame-start pulse
//   STREAM | popping N_SAMPLES samples, stalling while the FIFO is empty
//   GAP    | GAP_CYCLES idle cycles for the downstream end-of-frame result
module sample_framer
  import framer_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int N_SAMPLES  = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  output logic                    start,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] sample_out,
  output logic                    frame_active,
  output logic [CNT_W-1:0]        frame_cnt,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam int SW = cnt_width(N_SAMPLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [SW-1:0] LAST_SAMPLE = SW'(N_SAMPLES - 1);
  localparam logic [GW-1:0] GAP_LOAD    = GW'(GAP_CYCLES - 1);

  state_t            state_q, state_d;
  logic [SW-1:0]     smp_q, smp_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              start_q, start_d;
  logic              out_valid_q, out_valid_d;
  logic              active_q, active_d;
  logic [WIDTH-1:0]  sample_q, sample_d;
  logic [CNT_W-1:0]  frame_q, frame_d;
  logic              run_q, run_d;

  logic [WIDTH-1:0]  fifo_rd_data;
  logic              fifo_full, fifo_empty;
  logic              pop, wr;

  assign pop = (state_q == STREAM) && !fifo_empty;
  assign wr  = s_valid && s_ready;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr),
    .wr_data (s_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    smp_d       = smp_q;
    gap_d       = gap_q;
    frame_d     = frame_q;
    run_d       = 1'b1;
    case (state_q)
      IDLE:   if (enable && !fifo_empty) state_d = START;
      START:  state_d = STREAM;
      STREAM: begin
        if (pop) begin
          if (smp_q == LAST_SAMPLE) begin
            smp_d   = '0;
            frame_d = frame_q + CNT_W'(1);
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end else begin
            smp_d = smp_q + SW'(1);
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
    start_d     = (state_d == START);
    out_valid_d = pop;
    sample_d    = pop ? fifo_rd_data : sample_q;
    // The frame stays active through the registered copy of its last popped sample.
    active_d    = (state_d == START) || (state_d == STREAM) || pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      smp_q       <= '0;
      gap_q       <= '0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      active_q    <= 1'b0;
      sample_q    <= '0;
      frame_q     <= '0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      smp_q       <= smp_d;
      gap_q       <= gap_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      active_q    <= active_d;
      sample_q    <= sample_d;
      frame_q     <= frame_d;
      run_q       <= run_d;
    end
  end

`ifdef SAMPLE_FRAMER_DROP_EN
  logic [CNT_W-1:0] drop_q, drop_d;

  assign s_ready = run_q;

  always_comb begin
    drop_d = drop_q;
    if (wr && fifo_full && !pop && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  assign s_ready  = run_q && !fifo_full;
  assign drop_cnt = '0;
`endif

  assign start        = start_q;
  assign out_valid    = out_valid_q;
  assign sample_out   = sample_q;
  assign frame_active = active_q;
  assign frame_cnt    = frame_q;

endmodule
